// File: rtl/rv_pkg.sv
// Shared integer-pipeline definitions: register file geometry and the
// write-back request that travels from execute/memory into the register file.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that buffers long-latency write-back requests until
// they win the register file write port.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t push_data,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and long-latency results into one registered register file write
// per cycle and tracks destinations still waiting on a long-latency result.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int LSU_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]       alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]       lsu_data_i,
    input  logic                  sb_set_i,
    input  logic [REG_ADDR_W-1:0] sb_set_rd_i,
    output logic [NUM_REGS-1:0]   pend_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  reg_write_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    wb_req_t               fifo_head;
    wb_req_t               lsu_req;
    wb_req_t               winner;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  forced;
    logic                  have_winner;
    logic                  from_fifo;
    logic [3:0]            starve_cnt;
    logic [NUM_REGS-1:0]   pend;
    logic [NUM_REGS-1:0]   pend_next;

    assign lsu_req     = '{rd: lsu_rd_i, data: lsu_data_i};
    assign fifo_push   = lsu_valid_i && !fifo_full;
    assign lsu_ready_o = !fifo_full;
    assign alu_ready_o = !forced;
    assign pend_o      = pend;

    wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (lsu_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A starved FIFO head beats the ALU; otherwise the ALU wins and the FIFO
    // drains only on cycles the ALU leaves idle.
    always_comb begin
        forced      = !fifo_empty && (starve_cnt == STARVE_MAX);
        fifo_pop    = 1'b0;
        have_winner = 1'b0;
        winner      = fifo_head;
        if (forced) begin
            fifo_pop    = 1'b1;
            have_winner = 1'b1;
        end else if (alu_valid_i) begin
            have_winner = 1'b1;
            winner      = '{rd: alu_rd_i, data: alu_data_i};
        end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            have_winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Writes to x0 are swallowed here so the register file never sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_o <= 1'b0;
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
            from_fifo   <= 1'b0;
        end else begin
            reg_write_o <= have_winner && (winner.rd != '0);
            from_fifo   <= fifo_pop;
            if (have_winner && (winner.rd != '0)) begin
                rd_addr_o <= winner.rd;
                rd_data_o <= winner.data;
            end
        end
    end

    // Clear first so that a same-cycle set of the same register survives.
    always_comb begin
        pend_next = pend;
        if (reg_write_o && from_fifo) pend_next[rd_addr_o] = 1'b0;
        if (sb_set_i && (sb_set_rd_i != '0)) pend_next[sb_set_rd_i] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= pend_next;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_regfile_writeback;
    import rv_pkg::*;

    localparam int LSU_DEPTH    = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        sb_set_i;
    logic [4:0]  sb_set_rd_i;
    logic [31:0] pend_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        reg_write_o;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state
    wb_req_t     m_q[$];
    int          m_starve;
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_from_fifo;
    logic        m_alu_ready;
    logic        m_lsu_ready;

    regfile_writeback #(.LSU_DEPTH(LSU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_rd_i    (lsu_rd_i),
        .lsu_data_i  (lsu_data_i),
        .sb_set_i    (sb_set_i),
        .sb_set_rd_i (sb_set_rd_i),
        .pend_o      (pend_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .reg_write_o (reg_write_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        num_errors++;
        $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve    = 0;
        m_pend      = '0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_data      = '0;
        m_from_fifo = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        wb_req_t win;
        logic    have_win;
        logic    popped;
        logic    lsu_acc;
        int      occ;
        occ      = m_q.size();
        lsu_acc  = lsu_valid_i && (occ < LSU_DEPTH);
        have_win = 1'b0;
        popped   = 1'b0;
        win      = '0;
        if (occ > 0 && m_starve == STARVE_LIMIT) begin
            win = m_q[0]; popped = 1'b1; have_win = 1'b1;
        end else if (alu_valid_i) begin
            win = '{rd: alu_rd_i, data: alu_data_i}; have_win = 1'b1;
        end else if (occ > 0) begin
            win = m_q[0]; popped = 1'b1; have_win = 1'b1;
        end
        if (m_we && m_from_fifo) m_pend[m_addr] = 1'b0;
        if (sb_set_i && sb_set_rd_i != 0) m_pend[sb_set_rd_i] = 1'b1;
        if (occ == 0 || popped) m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
        m_we = have_win && (win.rd != 0);
        if (m_we) begin
            m_addr = win.rd;
            m_data = win.data;
        end
        m_from_fifo = popped;
        if (popped) void'(m_q.pop_front());
        if (lsu_acc) m_q.push_back('{rd: lsu_rd_i, data: lsu_data_i});
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic sbs, input logic [4:0] sbrd);
        @(negedge clk);
        alu_valid_i = av;  alu_rd_i = ard;  alu_data_i = adat;
        lsu_valid_i = lv;  lsu_rd_i = lrd;  lsu_data_i = ldat;
        sb_set_i    = sbs; sb_set_rd_i = sbrd;
        #1;
        m_alu_ready = !(m_q.size() > 0 && m_starve == STARVE_LIMIT);
        m_lsu_ready = (m_q.size() < LSU_DEPTH);
        checkOutput("reg_write", 32'(reg_write_o), 32'(m_we));
        checkOutput("rd_addr",   32'(rd_addr_o),   32'(m_addr));
        checkOutput("rd_data",   rd_data_o,        m_data);
        checkOutput("pend",      pend_o,           m_pend);
        checkOutput("alu_ready", 32'(alu_ready_o), 32'(m_alu_ready));
        checkOutput("lsu_ready", 32'(lsu_ready_o), 32'(m_lsu_ready));
        model_step();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; sb_set_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [4:0]  a_rd;
        logic [31:0] a_dat;
        logic        a_v;
        logic [4:0]  l_rd;
        logic [31:0] l_dat;
        logic        l_v;
        logic        s_v;
        logic [4:0]  s_rd;
        int          forced1, forced2, wr_a, wr_b, accept_z, k, seen_write;
        int          order[$];

        rst = 1'b1;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        sb_set_i = 0; sb_set_rd_i = 0;
        model_reset();
        applyReset();
        checkOutput("rst_we",        32'(reg_write_o), 32'd0);
        checkOutput("rst_addr",      32'(rd_addr_o),   32'd0);
        checkOutput("rst_data",      rd_data_o,        32'd0);
        checkOutput("rst_pend",      pend_o,           32'd0);
        checkOutput("rst_lsu_ready", 32'(lsu_ready_o), 32'd1);
        checkOutput("rst_alu_ready", 32'(alu_ready_o), 32'd1);

        // ALU write appears exactly one cycle after acceptance
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_we",   32'(reg_write_o), 32'd1);
        checkOutput("alu_addr", 32'(rd_addr_o),   32'd5);
        checkOutput("alu_data", rd_data_o,        32'hDEADBEEF);
        checkOutput("alu_pend", pend_o,           32'd0);

        // Long-latency write at +2, pending bit low at +3
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h12345678, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lsu_we",    32'(reg_write_o), 32'd1);
        checkOutput("lsu_addr",  32'(rd_addr_o),   32'd7);
        checkOutput("lsu_data",  rd_data_o,        32'h12345678);
        checkOutput("lsu_pend7", 32'(pend_o[7]),   32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lsu_pend7_clr", 32'(pend_o[7]), 32'd0);

        // Starvation: ALU busy every cycle with two LSU results queued
        applyReset();
        forced1 = -1; forced2 = -1; wr_a = -1; wr_b = -1;
        a_rd = 5'd1; a_dat = 32'h100;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, a_rd, a_dat, (i < 2), (i == 0) ? 5'd10 : 5'd11,
                          (i == 0) ? 32'hAAAA0000 : 32'hBBBB0000, 0, 0);
            if (!alu_ready_o) begin
                if (forced1 < 0) forced1 = i;
                else if (forced2 < 0) forced2 = i;
            end
            if (reg_write_o && rd_addr_o == 5'd10 && wr_a < 0) wr_a = i;
            if (reg_write_o && rd_addr_o == 5'd11 && wr_b < 0) wr_b = i;
            if (m_alu_ready) begin
                a_rd  = (a_rd == 5'd9) ? 5'd1 : a_rd + 5'd1;
                a_dat = a_dat + 32'd1;
            end
        end
        checkOutput("starve_forced1", 32'(forced1), 32'd5);
        checkOutput("starve_forced2", 32'(forced2), 32'd10);
        checkOutput("starve_wr_a",    32'(wr_a),    32'd6);
        checkOutput("starve_wr_b",    32'(wr_b),    32'd11);

        // Three back-to-back LSU results against a busy ALU
        applyReset();
        k = 0; accept_z = -1;
        order.delete();
        a_dat = 32'h200;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1, 5'd1, a_dat, (k < 3), 5'(20 + k), 32'hC0DE0000 + 32'(k), 0, 0);
            if (i == 2) checkOutput("full_lsu_ready", 32'(lsu_ready_o), 32'd0);
            if (reg_write_o && rd_addr_o >= 5'd20 && rd_addr_o <= 5'd22) order.push_back(int'(rd_addr_o));
            if (m_alu_ready) a_dat = a_dat + 32'd1;
            if (k < 3 && m_lsu_ready) begin
                if (k == 2) accept_z = i;
                k++;
            end
        end
        checkOutput("third_accept", 32'(accept_z), 32'd6);
        checkOutput("order_count",  32'(order.size()), 32'd3);
        for (int j = 0; j < 3; j++)
            checkOutput("order_rd", (j < order.size()) ? 32'(order[j]) : 32'hFFFFFFFF, 32'(20 + j));

        // x0 destinations never write and never mark pending
        applyReset();
        seen_write = 0;
        applyStimulus(1, 5'd0, 32'h11111111, 1, 5'd0, 32'h22222222, 1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            if (reg_write_o) seen_write++;
        end
        checkOutput("x0_writes", 32'(seen_write), 32'd0);
        checkOutput("x0_pend",   pend_o,          32'd0);

        // Reset while full with a pending bit
        applyReset();
        applyStimulus(1, 5'd1, 32'h300, 1, 5'd3, 32'h33, 1, 5'd3);
        applyStimulus(1, 5'd2, 32'h301, 1, 5'd4, 32'h44, 0, 0);
        applyStimulus(1, 5'd1, 32'h302, 0, 0, 0, 0, 0);
        checkOutput("pre_full",  32'(lsu_ready_o), 32'd0);
        checkOutput("pre_pend3", 32'(pend_o[3]),   32'd1);
        applyReset();
        checkOutput("mid_rst_we",        32'(reg_write_o), 32'd0);
        checkOutput("mid_rst_pend",      pend_o,           32'd0);
        checkOutput("mid_rst_lsu_ready", 32'(lsu_ready_o), 32'd1);
        checkOutput("mid_rst_alu_ready", 32'(alu_ready_o), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_rst_no_write", 32'(reg_write_o), 32'd0);

        // Random traffic honouring the valid/ready hold rules
        a_v = 0; a_rd = 0; a_dat = 0;
        l_v = 0; l_rd = 0; l_dat = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(a_v && !m_alu_ready)) begin
                a_v   = ($urandom_range(0, 99) < 45);
                a_rd  = 5'($urandom_range(0, 31));
                a_dat = $urandom;
            end
            if (!(l_v && !m_lsu_ready)) begin
                l_v   = ($urandom_range(0, 99) < 40);
                l_rd  = 5'($urandom_range(0, 31));
                l_dat = $urandom;
            end
            s_v  = ($urandom_range(0, 99) < 25);
            s_rd = 5'($urandom_range(0, 31));
            if (m_pend[s_rd]) s_v = 1'b0;
            applyStimulus(a_v, a_rd, a_dat, l_v, l_rd, l_dat, s_v, s_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
